// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Default sizing constants and the address type shared by the
//               scoreboarded register file, its interface and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NREGS    = 16;
    localparam int DEF_PC_SHIFT = 2;
    localparam int DEF_ADDR_W   = $clog2(DEF_NREGS);

    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Read, write, issue and writeback signals of the scoreboarded
//               register file. The master drives requests; the slave is the
//               register file itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS
) ();

    localparam int ADDR_W = $clog2(NREGS);

    logic [DATA_W-1:0]              pc;
    logic [ADDR_W-1:0]              rd_addr_0;
    logic [ADDR_W-1:0]              rd_addr_1;
    logic [DATA_W-1:0]              rd_data_0;
    logic [DATA_W-1:0]              rd_data_1;
    logic                           rd_busy_0;
    logic                           rd_busy_1;
    logic                           wa_en;
    logic [ADDR_W-1:0]              wa_addr;
    logic [DATA_W-1:0]              wa_data;
    logic                           issue_en;
    logic [ADDR_W-1:0]              issue_addr;
    logic                           wb_valid;
    logic [ADDR_W-1:0]              wb_addr;
    logic [DATA_W-1:0]              wb_data;
    logic                           wb_ready;
    logic [NREGS-1:0]               busy_vec;
    logic                           err;
    logic [NREGS-2:0][DATA_W-1:0]   dbg_regs;

    modport master (
        output pc, rd_addr_0, rd_addr_1,
        output wa_en, wa_addr, wa_data,
        output issue_en, issue_addr,
        output wb_valid, wb_addr, wb_data,
        input  rd_data_0, rd_data_1, rd_busy_0, rd_busy_1,
        input  wb_ready, busy_vec, err, dbg_regs
    );

    modport slave (
        input  pc, rd_addr_0, rd_addr_1,
        input  wa_en, wa_addr, wa_data,
        input  issue_en, issue_addr,
        input  wb_valid, wb_addr, wb_data,
        output rd_data_0, rd_data_1, rd_busy_0, rd_busy_1,
        output wb_ready, busy_vec, err, dbg_regs
    );

endinterface
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending-write bits for long-latency ops, the
//               busy view seen by the read ports, and the sticky hazard flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NREGS  = DEF_NREGS,
    parameter int PC_REG = NREGS - 1,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic              wb_fire,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic              rd_busy_0,
    output logic              rd_busy_1,
    output logic [NREGS-1:0]  busy_vec,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] busy_nxt;
    logic             err_q;
    logic             waw_hazard;
    logic             orphan_wb;
    logic             wa_hazard;

    // Per-register clear (writeback) and set (issue) strobes; the PC alias
    // can never become pending.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int a = 0; a < NREGS; a++) begin
            clr_vec[a] = wb_fire && (wb_addr == ADDR_W'(a));
            set_vec[a] = issue_en && (issue_addr == ADDR_W'(a)) && (a != PC_REG);
        end
    end

    // Set after clear, so an issue landing with a writeback keeps the bit.
    assign busy_nxt = (busy_q & ~clr_vec) | set_vec;

    // Hazards are diagnostic only: the offending access still takes effect.
    assign waw_hazard = issue_en && busy_q[issue_addr] && !clr_vec[issue_addr];
    assign orphan_wb  = wb_fire && !busy_q[wb_addr];
    assign wa_hazard  = wa_en && busy_q[wa_addr];

    // Scoreboard bits and sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            err_q  <= err_q | waw_hazard | orphan_wb | wa_hazard;
        end
    end

    // A writeback retiring this cycle already makes the register readable.
    assign rd_busy_0 = busy_q[rd_addr_0] && !clr_vec[rd_addr_0] && (rd_addr_0 != PC_ADDR);
    assign rd_busy_1 = busy_q[rd_addr_1] && !clr_vec[rd_addr_1] && (rd_addr_1 != PC_ADDR);

    assign busy_vec = busy_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Two-read register file with a single-cycle write port, a
//               stallable long-latency writeback port, write-through bypass
//               and a pending-write scoreboard. The top register reads as
//               the scaled program counter.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb import regfile_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int PC_REG   = NREGS - 1,
    parameter int PC_SHIFT = DEF_PC_SHIFT
) (
    input  logic       clk,
    input  logic       reset,
    regfile_sb_if.slave bus
);

    localparam int                ADDR_W  = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wb_ready;
    logic              wb_fire;
    logic [DATA_W-1:0] pc_alias;

    // Port A always wins; the writeback side simply waits a cycle.
    assign wb_ready = !reset && !bus.wa_en;
    assign wb_fire  = bus.wb_valid && wb_ready;
    assign pc_alias = bus.pc >> PC_SHIFT;

    // Register array update; the PC alias entry is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wa_en) begin
            if (bus.wa_addr != PC_ADDR) begin
                regs[bus.wa_addr] <= bus.wa_data;
            end
        end else if (wb_fire) begin
            if (bus.wb_addr != PC_ADDR) begin
                regs[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    // Read port 0: PC alias, then port A bypass, then writeback bypass.
    always_comb begin
        bus.rd_data_0 = regs[bus.rd_addr_0];
        if (bus.rd_addr_0 == PC_ADDR) begin
            bus.rd_data_0 = pc_alias;
        end else if (bus.wa_en && (bus.wa_addr == bus.rd_addr_0)) begin
            bus.rd_data_0 = bus.wa_data;
        end else if (wb_fire && (bus.wb_addr == bus.rd_addr_0)) begin
            bus.rd_data_0 = bus.wb_data;
        end
    end

    // Read port 1: same priority as port 0.
    always_comb begin
        bus.rd_data_1 = regs[bus.rd_addr_1];
        if (bus.rd_addr_1 == PC_ADDR) begin
            bus.rd_data_1 = pc_alias;
        end else if (bus.wa_en && (bus.wa_addr == bus.rd_addr_1)) begin
            bus.rd_data_1 = bus.wa_data;
        end else if (wb_fire && (bus.wb_addr == bus.rd_addr_1)) begin
            bus.rd_data_1 = bus.wb_data;
        end
    end

    // Debug view lists the architectural registers, skipping the PC alias.
    for (genvar j = 0; j < NREGS - 1; j++) begin : g_dbg
        localparam int SRC = (j < PC_REG) ? j : j + 1;
        assign bus.dbg_regs[j] = regs[SRC];
    end

    assign bus.wb_ready = wb_ready;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .PC_REG (PC_REG),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (bus.issue_en),
        .issue_addr (bus.issue_addr),
        .wa_en      (bus.wa_en),
        .wa_addr    (bus.wa_addr),
        .wb_fire    (wb_fire),
        .wb_addr    (bus.wb_addr),
        .rd_addr_0  (bus.rd_addr_0),
        .rd_addr_1  (bus.rd_addr_1),
        .rd_busy_0  (bus.rd_busy_0),
        .rd_busy_1  (bus.rd_busy_1),
        .busy_vec   (bus.busy_vec),
        .err        (bus.err)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed and randomized bench for regfile_sb with a
//               behavioural register/scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW  = 16;
    localparam int NR  = 16;
    localparam int PCR = NR - 1;
    localparam int PSH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .NREGS(NR)) bus ();

    regfile_sb #(
        .DATA_W   (DW),
        .NREGS    (NR),
        .PC_REG   (PCR),
        .PC_SHIFT (PSH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural state: plain arrays updated once per clock.
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    bit            m_err;
    bit            last_fire;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input addr_t a, input bit fire);
        if (int'(a) == PCR)                        return bus.pc >> PSH;
        if (bus.wa_en && bus.wa_addr == a)         return bus.wa_data;
        if (fire && bus.wb_addr == a)              return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_rd_busy(input addr_t a, input bit fire);
        return m_busy[a] && !(fire && bus.wb_addr == a) && (int'(a) != PCR);
    endfunction

    // Check every output against the model, then advance the model one clock.
    task automatic tick();
        bit            fire;
        logic [255:0]  exp_dbg;
        logic [NR-1:0] exp_busy;
        #1;
        fire = bus.wb_valid && !reset && !bus.wa_en;
        exp_dbg = '0;
        for (int j = 0; j < NR - 1; j++) exp_dbg[j*DW +: DW] = m_regs[j];
        for (int j = 0; j < NR; j++) exp_busy[j] = m_busy[j];
        check("wb_ready",  bus.wb_ready,  !reset && !bus.wa_en);
        check("rd_data_0", bus.rd_data_0, m_read(bus.rd_addr_0, fire));
        check("rd_data_1", bus.rd_data_1, m_read(bus.rd_addr_1, fire));
        check("rd_busy_0", bus.rd_busy_0, m_rd_busy(bus.rd_addr_0, fire));
        check("rd_busy_1", bus.rd_busy_1, m_rd_busy(bus.rd_addr_1, fire));
        check("busy_vec",  bus.busy_vec,  exp_busy);
        check("err",       bus.err,       m_err);
        check("dbg_regs",  bus.dbg_regs,  exp_dbg);
        @(posedge clk);
        if (reset) begin
            for (int j = 0; j < NR; j++) begin
                m_regs[j] = '0;
                m_busy[j] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            if (bus.issue_en && m_busy[bus.issue_addr] && !(fire && bus.wb_addr == bus.issue_addr))
                m_err = 1'b1;
            if (fire && !m_busy[bus.wb_addr]) m_err = 1'b1;
            if (bus.wa_en && m_busy[bus.wa_addr]) m_err = 1'b1;
            if (bus.wa_en && int'(bus.wa_addr) != PCR) m_regs[bus.wa_addr] = bus.wa_data;
            else if (fire && int'(bus.wb_addr) != PCR) m_regs[bus.wb_addr] = bus.wb_data;
            if (fire) m_busy[bus.wb_addr] = 1'b0;
            if (bus.issue_en && int'(bus.issue_addr) != PCR) m_busy[bus.issue_addr] = 1'b1;
        end
        last_fire = fire;
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        bus.pc         = 16'h0040;
        bus.rd_addr_0  = 4'd3;
        bus.rd_addr_1  = 4'd15;
        bus.wa_en      = 1'b0;
        bus.wa_addr    = '0;
        bus.wa_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.wb_valid   = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
        for (int j = 0; j < NR; j++) begin
            m_regs[j] = '0;
            m_busy[j] = 1'b0;
        end
        m_err     = 1'b0;
        last_fire = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tick();

        // Reset state and PC alias.
        reset = 1'b0;
        #1;
        check("reset_r3",   bus.rd_data_0, 16'h0000);
        check("r15_alias",  bus.rd_data_1, 16'h0010);
        check("reset_busy", bus.busy_vec,  16'h0000);
        check("reset_rdy",  bus.wb_ready,  1'b1);
        tick();

        // Port A write-through and array update.
        bus.wa_en = 1'b1; bus.wa_addr = 4'd2; bus.wa_data = 16'hBEEF; bus.rd_addr_0 = 4'd2;
        #1;
        check("wa_bypass", bus.rd_data_0, 16'hBEEF);
        tick();
        bus.wa_en = 1'b0;
        #1;
        check("r2_array", bus.dbg_regs[2], 16'hBEEF);
        tick();

        // Issue then writeback to r5.
        bus.issue_en = 1'b1; bus.issue_addr = 4'd5;
        tick();
        bus.issue_en = 1'b0; bus.rd_addr_0 = 4'd5;
        #1;
        check("r5_busy_vec", bus.busy_vec[5], 1'b1);
        check("r5_rd_busy",  bus.rd_busy_0,   1'b1);
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 16'h1234;
        #1;
        check("r5_wb_unbusy", bus.rd_busy_0, 1'b0);
        check("r5_wb_bypass", bus.rd_data_0, 16'h1234);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("r5_cleared", bus.busy_vec[5], 1'b0);
        check("r5_no_err",  bus.err,         1'b0);
        tick();

        // Port A stalls the writeback port.
        bus.issue_en = 1'b1; bus.issue_addr = 4'd7;
        tick();
        bus.issue_en = 1'b0;
        bus.wa_en = 1'b1; bus.wa_addr = 4'd1; bus.wa_data = 16'h1111;
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 16'h7777;
        #1;
        check("stall_ready", bus.wb_ready, 1'b0);
        tick();
        check("stall_r1", bus.dbg_regs[1], 16'h1111);
        check("stall_r7", bus.dbg_regs[7], 16'h0000);
        bus.wa_en = 1'b0;
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("late_r7",  bus.dbg_regs[7], 16'h7777);
        check("late_err", bus.err,         1'b0);

        // Writes to the PC alias are dropped.
        bus.wa_en = 1'b1; bus.wa_addr = 4'd15; bus.wa_data = 16'hFFFF; bus.rd_addr_1 = 4'd15;
        #1;
        check("pc_wa_read", bus.rd_data_1, 16'h0010);
        tick();
        bus.wa_en = 1'b0;
        tick();

        // WAW on r4, sticky err, set-wins on simultaneous issue/writeback.
        bus.issue_en = 1'b1; bus.issue_addr = 4'd4;
        tick();
        tick();
        bus.issue_en = 1'b0;
        #1;
        check("waw_err", bus.err, 1'b1);
        tick();
        tick();
        check("err_sticky", bus.err, 1'b1);
        bus.issue_en = 1'b1; bus.issue_addr = 4'd4;
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 16'h4444;
        tick();
        bus.issue_en = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd15; bus.wb_data = 16'hFFFF;
        #1;
        check("set_wins", bus.busy_vec[4], 1'b1);
        tick();
        bus.wb_valid = 1'b0;
        tick();

        // Reset clears state; a writeback held across reset lands afterwards as an orphan.
        reset = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 16'h3333;
        tick();
        reset = 1'b0;
        #1;
        check("rst_err",  bus.err,      1'b0);
        check("rst_busy", bus.busy_vec, 16'h0000);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("orphan_err", bus.err, 1'b1);
        tick();

        // Randomized traffic; writeback operands stay stable until accepted.
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 39) == 0);
            bus.pc         = DW'($urandom);
            bus.rd_addr_0  = addr_t'($urandom);
            bus.rd_addr_1  = addr_t'($urandom);
            bus.wa_en      = ($urandom_range(0, 3) == 0);
            bus.wa_addr    = addr_t'($urandom);
            bus.wa_data    = DW'($urandom);
            bus.issue_en   = ($urandom_range(0, 2) == 0);
            bus.issue_addr = addr_t'($urandom);
            if (!bus.wb_valid || last_fire) begin
                int start;
                bus.wb_valid = ($urandom_range(0, 1) == 1);
                start        = int'($urandom_range(0, NR - 1));
                bus.wb_addr  = addr_t'(start);
                for (int k = 0; k < NR; k++) begin
                    if (m_busy[(start + k) % NR]) begin
                        bus.wb_addr = addr_t'((start + k) % NR);
                        break;
                    end
                end
                bus.wb_data = DW'($urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core 16-bit register file.
- Adds a second writeback port for long-latency (FP) units and a per-register scoreboard of pending writes.
- Adds write-through bypass on both read ports and a sticky hazard-error flag.
- Sits between decode (reads, issue) and the ALU/FPU writeback paths; the top register remains a read-only alias of the scaled PC.

Parameters:
- DATA_W, 16, register and data width.
- NREGS, 16, number of architectural registers including the PC alias; ADDR_W = $clog2(NREGS), derived.
- PC_REG, NREGS-1, index that reads the PC alias; writes and issues to it are ignored.
- PC_SHIFT, 2, right shift applied to pc for the alias value.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- pc  in  DATA_W  current program counter.
- rd_addr_0, rd_addr_1  in  ADDR_W  async read addresses.
- rd_data_0, rd_data_1  out  DATA_W  read data (combinational, bypassed).
- rd_busy_0, rd_busy_1  out  1  addressed register has a pending long-latency write.
- wa_en  in  1  port A (single-cycle pipeline) write enable.
- wa_addr  in  ADDR_W  port A address.
- wa_data  in  DATA_W  port A data.
- issue_en  in  1  long-latency op issued; marks its destination pending.
- issue_addr  in  ADDR_W  destination of the issued op.
- wb_valid  in  1  long-latency writeback valid.
- wb_addr  in  ADDR_W  writeback address.
- wb_data  in  DATA_W  writeback data.
- wb_ready  out  1  writeback accepted this cycle.
- busy_vec  out  NREGS  scoreboard state.
- err  out  1  sticky hazard error.
- dbg_regs  out  [NREGS-2:0][DATA_W-1:0]  register contents for debug/testbench.

Behaviour:
- One clock, clk; reset is synchronous and active-high, port named reset. On reset: all registers 0, busy_vec 0, err 0. wb_ready is 0 while reset is high.
- wb handshake: wb_ready = ~reset & ~wa_en, so port A has priority and wb stalls. wb_fire = wb_valid & wb_ready. The wb side must hold wb_addr/wb_data stable until fire.
- Writes, on posedge:
  - wa_en: reg[wa_addr] <= wa_data.
  - else wb_fire: reg[wb_addr] <= wb_data.
  - Both write ports are ignored when their address is PC_REG.
- Reads are combinational and use this priority:
  1. addr==PC_REG -> pc >> PC_SHIFT, zero-filled.
  2. wa_en & wa_addr==addr -> wa_data.
  3. wb_fire & wb_addr==addr -> wb_data.
  4. otherwise reg[addr].
  Same-cycle writes are therefore visible (write-through).
- Scoreboard update per cycle: busy[a] next = (busy[a] & ~(wb_fire & wb_addr==a)) | (issue_en & issue_addr==a & a!=PC_REG).
  - Simultaneous issue and wb_fire to the same register: set wins, busy stays 1.
- rd_busy_n = busy[rd_addr_n] & ~(wb_fire & wb_addr==rd_addr_n). It is always 0 for PC_REG.
- err is set, and held until reset, on any of:
  - issue_en to a register that is busy and not cleared by wb_fire that cycle (WAW);
  - wb_fire to a register whose busy bit is 0 (orphan writeback);
  - wa_en to a busy register.
  In every case the write or issue still takes effect; err is diagnostic only.
- Latency:
  - Written data is readable in the same cycle through bypass, and from the array on the next cycle.
  - busy_vec updates 1 cycle after issue or fire.
- Reset asserted mid-operation clears all pending bits. A wb_valid held across reset is accepted only after reset deasserts, and then flags err as an orphan writeback.

Decomposition:
- Package regfile_pkg holds default DATA_W/NREGS/PC_SHIFT constants and an addr_t typedef derived from ADDR_W.
- Sub-module regfile_scoreboard (NREGS): busy_vec, rd_busy logic and err generation. The parent holds the array, write muxing and bypass.

Test Plan:
- Reset, then read r3 and r15 with pc=0x0040 -> rd_data_0=0, rd_data_1=0x0010, busy_vec=0, err=0, wb_ready=1.
- wa_en, wa_addr=2, wa_data=0xBEEF, rd_addr_0=2 in the same cycle -> rd_data_0=0xBEEF same cycle; after the edge, dbg_regs[2]=0xBEEF.
- issue_en addr=5 -> next cycle busy_vec[5]=1, rd_busy_0=1. Then wb_valid addr=5 data=0x1234 -> same cycle rd_busy_0=0 and rd_data_0=0x1234; next cycle busy_vec[5]=0, err=0.
- wa_en addr=1 and wb_valid addr=7 in the same cycle -> wb_ready=0, only r1 written. The next cycle with wa_en=0 -> wb fires, r7 written.
- Write 0xFFFF to addr 15 on either port -> no change to the array; reading r15 still returns pc>>2.
- issue to r4 twice without a writeback -> err=1 and stays 1. Same-cycle issue and wb to r4 -> busy_vec[4] stays 1. reset -> err=0, busy_vec=0.
